// File: rtl/cpu_dbg_pkg.sv
// Shared types and codes for the run/halt debug sequencer of the single-cycle core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, host command codes, halt cause codes, dump index width.
package cpu_dbg_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2,
        ST_DUMP = 2'd3
    } dbg_state_e;

    localparam logic [1:0] CMD_HALT = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_DUMP = 2'b11;

    localparam logic [1:0] CAUSE_HOST  = 2'd0;
    localparam logic [1:0] CAUSE_BP    = 2'd1;
    localparam logic [1:0] CAUSE_STEP  = 2'd2;
    localparam logic [1:0] CAUSE_LIMIT = 2'd3;

    // Register index width on the core's reg_sel debug port.
    localparam int IDX_W = 5;

endpackage

// File: rtl/cpu_dbg_ctrl_if.sv
// Host-side bundle of the debug sequencer: command handshake plus register dump stream.
// Latency: n/a (wires only).
// Backpressure: cmd uses cmd_valid/cmd_ready; dump beats use dump_valid/dump_ready.
//
// master: host/debug logic (drives cmd_valid, cmd, dump_ready)
// slave : cpu_dbg_ctrl      (drives cmd_ready, dump_valid, dump_idx, dump_data)
interface cpu_dbg_ctrl_if #(
    parameter int DW = 32
);
    import cpu_dbg_pkg::*;

    logic             cmd_valid;
    logic [1:0]       cmd;
    logic             cmd_ready;
    logic             dump_valid;
    logic [IDX_W-1:0] dump_idx;
    logic [DW-1:0]    dump_data;
    logic             dump_ready;

    modport master (
        output cmd_valid, cmd, dump_ready,
        input  cmd_ready, dump_valid, dump_idx, dump_data
    );

    modport slave (
        input  cmd_valid, cmd, dump_ready,
        output cmd_ready, dump_valid, dump_idx, dump_data
    );

endinterface

// File: rtl/cpu_dbg_dump.sv
// Register-file sweeper: walks reg_sel 0..REG_N-1 and presents each value as a dump beat.
// Latency: first beat valid the cycle after start; one beat per cycle while dump_ready is high.
// Backpressure: dump_ready low holds dump_valid/dump_idx/reg_sel indefinitely.
//
// Ports: clk, rstn (sync, active low), start (strobe from parent FSM), reg_data (core RF value for
// reg_sel), dump_ready (sink), reg_sel (core RF select), dump_valid/dump_idx/dump_data (beat),
// done (strobe: final beat accepted this cycle).
module cpu_dbg_dump
    import cpu_dbg_pkg::*;
#(
    parameter int DW    = 32,
    parameter int REG_N = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [DW-1:0]    reg_data,
    input  logic             dump_ready,
    output logic [IDX_W-1:0] reg_sel,
    output logic             dump_valid,
    output logic [IDX_W-1:0] dump_idx,
    output logic [DW-1:0]    dump_data,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_N - 1);

    logic active;
    logic beat;

    assign beat = active & dump_ready;
    assign done = beat & (reg_sel == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            active  <= 1'b0;
            reg_sel <= '0;
        end else if (start) begin
            active  <= 1'b1;
            reg_sel <= '0;
        end else if (beat) begin
            if (reg_sel == LAST_IDX) begin
                // Park the select at 0 so the core port is in a known state after the dump.
                active  <= 1'b0;
                reg_sel <= '0;
            end else begin
                reg_sel <= reg_sel + IDX_W'(1);
            end
        end
    end

    // Core register file read is combinational, so the data lines up with reg_sel directly.
    assign dump_valid = active;
    assign dump_idx   = reg_sel;
    assign dump_data  = reg_data;

endmodule

// File: rtl/cpu_dbg_ctrl.sv
// Run/halt sequencer for the single-cycle core: gates cpu_en, halts on breakpoint/host/step/limit, dumps RF.
// Latency: breakpoint/limit halt is same-cycle (cpu_en drops combinationally); host HALT takes effect next cycle.
// Backpressure: cmd_ready low in STEP and DUMP; dump stream stalls on dump_ready low.
//
// Ports: clk, rstn (sync, active low), pc, bp_en, bp_addr, cyc_limit (0 = off), cpu_en, halted,
// halt_cause, cycle_cnt, reg_sel/reg_data (core debug port), bus (cmd handshake + dump stream).
// Build option: define CPU_DBG_CYCLIMIT_EN to enable the executed-cycle limit halt.
module cpu_dbg_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int REG_N        = 32,
    parameter int RUN_AT_RESET = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [AW-1:0]    pc,
    input  logic             bp_en,
    input  logic [AW-1:0]    bp_addr,
    input  logic [31:0]      cyc_limit,
    output logic             cpu_en,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [31:0]      cycle_cnt,
    output logic [IDX_W-1:0] reg_sel,
    input  logic [DW-1:0]    reg_data,
    cpu_dbg_ctrl_if.slave    bus
);

    localparam dbg_state_e RST_STATE = (RUN_AT_RESET != 0) ? ST_RUN : ST_HALT;

    dbg_state_e state, state_nxt;
    logic [1:0] cause_nxt;
    logic       skip, skip_nxt;
    logic       bp_hit, lim_hit;
    logic       cmd_acc;
    logic       dump_start, dump_done;

    // skip masks the breakpoint for the first resumed instruction so a RUN from a
    // breakpoint halt executes the instruction sitting at bp_addr instead of re-halting.
    assign bp_hit = bp_en & (pc == bp_addr) & ~skip;

`ifdef CPU_DBG_CYCLIMIT_EN
    assign lim_hit = (cyc_limit != 32'd0) & (cycle_cnt == cyc_limit);
`else
    logic unused_cyc_limit;
    assign unused_cyc_limit = ^cyc_limit;
    assign lim_hit          = 1'b0;
`endif

    assign bus.cmd_ready = (state == ST_RUN) || (state == ST_HALT);
    assign cmd_acc       = bus.cmd_valid & bus.cmd_ready;
    assign halted        = (state == ST_HALT);

    always_comb begin
        state_nxt  = state;
        cause_nxt  = halt_cause;
        cpu_en     = 1'b0;
        dump_start = 1'b0;
        skip_nxt   = skip;
        case (state)
            ST_RUN: begin
                cpu_en = ~bp_hit & ~lim_hit;
                // Breakpoint outranks the limit; both outrank a same-cycle host HALT.
                if (bp_hit) begin
                    state_nxt = ST_HALT;
                    cause_nxt = CAUSE_BP;
                end else if (lim_hit) begin
                    state_nxt = ST_HALT;
                    cause_nxt = CAUSE_LIMIT;
                end else if (cmd_acc && (bus.cmd == CMD_HALT)) begin
                    state_nxt = ST_HALT;
                    cause_nxt = CAUSE_HOST;
                end
            end
            ST_HALT: begin
                if (cmd_acc) begin
                    case (bus.cmd)
                        CMD_RUN: begin
                            state_nxt = ST_RUN;
                        end
                        CMD_STEP: begin
                            state_nxt = ST_STEP;
                        end
                        CMD_DUMP: begin
                            state_nxt  = ST_DUMP;
                            dump_start = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_STEP: begin
                cpu_en    = 1'b1;
                state_nxt = ST_HALT;
                cause_nxt = CAUSE_STEP;
            end
            ST_DUMP: begin
                if (dump_done) begin
                    state_nxt = ST_HALT;
                end
            end
            default: begin
                state_nxt = ST_HALT;
            end
        endcase

        // skip lives for exactly one executed instruction.
        if (cpu_en) begin
            skip_nxt = 1'b0;
        end
        if ((state == ST_HALT) && cmd_acc && (bus.cmd == CMD_RUN)) begin
            skip_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= RST_STATE;
            halt_cause <= CAUSE_HOST;
            skip       <= 1'b0;
            cycle_cnt  <= 32'd0;
        end else begin
            state      <= state_nxt;
            halt_cause <= cause_nxt;
            skip       <= skip_nxt;
            if (cpu_en) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
        end
    end

    cpu_dbg_dump #(
        .DW    (DW),
        .REG_N (REG_N)
    ) u_dump (
        .clk        (clk),
        .rstn       (rstn),
        .start      (dump_start),
        .reg_data   (reg_data),
        .dump_ready (bus.dump_ready),
        .reg_sel    (reg_sel),
        .dump_valid (bus.dump_valid),
        .dump_idx   (bus.dump_idx),
        .dump_data  (bus.dump_data),
        .done       (dump_done)
    );

endmodule
